// File: rtl/bram_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_writer
//  Description : Writes a counted burst of valid/ready stream words into BRAM
//                port A at consecutive (wrapping) addresses, then pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_stream_writer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] words_left
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] words_left_q, words_left_d;
    logic              bram_ena_q, bram_ena_d;
    logic [ADDR_W-1:0] bram_addra_q, bram_addra_d;
    logic [DATA_W-1:0] bram_dina_q, bram_dina_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        bram_ena_d   = 1'b0;
        bram_addra_d = bram_addra_q;
        bram_dina_d  = bram_dina_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len != '0) begin
                        state_d      = S_WRITE;
                        addr_d       = base_addr;
                        words_left_d = len;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                busy_d = 1'b1;
                // abort wins over a same-cycle handshake; that word is discarded
                if (abort) begin
                    state_d      = S_IDLE;
                    busy_d       = 1'b0;
                    aborted_d    = 1'b1;
                    words_left_d = '0;
                end else if (s_valid) begin
                    bram_ena_d   = 1'b1;
                    bram_addra_d = addr_q;
                    bram_dina_d  = s_data;
                    addr_d       = addr_q + ADDR_W'(1);
                    words_left_d = words_left_q - ADDR_W'(1);
                    if (words_left_q == ADDR_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                words_left_d = '0;
            end
            default: begin
                state_d      = S_IDLE;
                words_left_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            bram_ena_q   <= 1'b0;
            bram_addra_q <= '0;
            bram_dina_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            bram_ena_q   <= bram_ena_d;
            bram_addra_q <= bram_addra_d;
            bram_dina_q  <= bram_dina_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Writes are the only port-A operation, so write enable tracks enable.
    assign s_ready    = (state_q == S_WRITE);
    assign bram_ena   = bram_ena_q;
    assign bram_wea   = bram_ena_q;
    assign bram_addra = bram_addra_q;
    assign bram_dina  = bram_dina_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign words_left = words_left_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_stream_writer
//  Description : Directed plus randomized checks of bram_stream_writer against
//                a transfer-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_stream_writer;

    logic        clk = 1'b0;
    logic        rst, start, abort, s_valid;
    logic [15:0] base_addr, len, s_data;
    logic        s_ready, bram_ena, bram_wea, busy, done, aborted;
    logic [15:0] bram_addra, bram_dina, words_left;

    bram_stream_writer #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dina(bram_dina), .busy(busy), .done(done), .aborted(aborted),
        .words_left(words_left)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transfer-level model: 0 = idle, 1 = accepting words, 2 = finishing
    int          m_phase = 0;
    int          m_rem   = 0;
    int          m_addr  = 0;
    logic        e_ena, e_done, e_abt;
    logic [15:0] e_addra = 16'h0, e_dina = 16'h0;

    int n_strobe = 0, n_done = 0, n_abt = 0, n_busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_strobe = 0; n_done = 0; n_abt = 0; n_busy = 0;
    endtask

    // One clock: predict from current inputs, advance, compare all outputs.
    task automatic step();
        chk("s_ready", 32'(s_ready), 32'(m_phase == 1));
        e_ena = 1'b0; e_done = 1'b0; e_abt = 1'b0;
        if (rst) begin
            m_phase = 0; m_rem = 0; m_addr = 0; e_addra = 16'h0; e_dina = 16'h0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    if (len == 16'h0) m_phase = 2;
                    else begin
                        m_phase = 1; m_rem = int'(len); m_addr = int'(base_addr);
                    end
                end
                1: if (abort) begin
                    m_phase = 0; m_rem = 0; e_abt = 1'b1;
                end else if (s_valid) begin
                    e_ena   = 1'b1;
                    e_addra = 16'(m_addr);
                    e_dina  = s_data;
                    m_addr  = (m_addr + 1) % 65536;
                    m_rem   = m_rem - 1;
                    if (m_rem == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        e_done = (m_phase == 2);
        @(posedge clk);
        #1;
        chk("bram_ena",   32'(bram_ena),   32'(e_ena));
        chk("bram_wea",   32'(bram_wea),   32'(e_ena));
        chk("bram_addra", 32'(bram_addra), 32'(e_addra));
        chk("bram_dina",  32'(bram_dina),  32'(e_dina));
        chk("busy",       32'(busy),       32'(m_phase != 0));
        chk("done",       32'(done),       32'(e_done));
        chk("aborted",    32'(aborted),    32'(e_abt));
        chk("words_left", 32'(words_left), 32'(m_rem));
        if (bram_ena === 1'b1) n_strobe++;
        if (done === 1'b1)     n_done++;
        if (aborted === 1'b1)  n_abt++;
        if (busy === 1'b1)     n_busy++;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    endtask

    initial begin
        logic [5:0] pat;
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        base_addr = 16'h0; len = 16'h0; s_data = 16'h0;
        @(posedge clk);
        #1;
        step();
        idle_inputs();
        step();

        // Reset held three cycles in the middle of a transfer
        start = 1'b1; base_addr = 16'h0100; len = 16'd5; step();
        start = 1'b0; s_valid = 1'b1;
        s_data = 16'h1111; step();
        s_data = 16'h2222; step();
        clear_counts();
        rst = 1'b1; s_data = 16'h3333;
        repeat (3) step();
        chk("t1_strobes", 32'(n_strobe), 32'd0);
        idle_inputs(); step();

        // Four-word burst at 0x0010
        clear_counts();
        start = 1'b1; base_addr = 16'h0010; len = 16'd4; step();
        start = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'h00A0 + 16'(i); step();
        end
        s_valid = 1'b0; step();
        chk("t2_strobes", 32'(n_strobe), 32'd4);
        chk("t2_done", 32'(n_done), 32'd1);

        // Address wrap past 0xFFFF
        clear_counts();
        start = 1'b1; base_addr = 16'hFFFE; len = 16'd3; step();
        start = 1'b0; s_valid = 1'b1;
        repeat (3) begin s_data = 16'($urandom); step(); end
        s_valid = 1'b0; step();
        chk("t3_wrap_addr", 32'(bram_addra), 32'h0000);
        chk("t3_done", 32'(n_done), 32'd1);

        // Throttled source
        clear_counts();
        start = 1'b1; base_addr = 16'h0200; len = 16'd3; step();
        start = 1'b0;
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            s_valid = pat[i]; s_data = 16'($urandom); step();
        end
        s_valid = 1'b0; step();
        chk("t4_strobes", 32'(n_strobe), 32'd3);

        // Zero-length request
        clear_counts();
        start = 1'b1; base_addr = 16'h0300; len = 16'd0; step();
        start = 1'b0; step(); step();
        chk("t5_strobes", 32'(n_strobe), 32'd0);
        chk("t5_busy_cycles", 32'(n_busy), 32'd1);
        chk("t5_done", 32'(n_done), 32'd1);

        // Abort after two of five words, with a word offered in the abort cycle
        clear_counts();
        start = 1'b1; base_addr = 16'h0400; len = 16'd5; step();
        start = 1'b0; s_valid = 1'b1;
        s_data = 16'hBEE0; step();
        s_data = 16'hBEE1; step();
        abort = 1'b1; s_data = 16'hBEE2; step();
        abort = 1'b0; s_valid = 1'b0;
        chk("t6_strobes", 32'(n_strobe), 32'd2);
        chk("t6_aborted", 32'(n_abt), 32'd1);
        chk("t6_no_done", 32'(n_done), 32'd0);
        start = 1'b1; base_addr = 16'h0800; len = 16'd2; step();
        start = 1'b0; s_valid = 1'b1;
        s_data = 16'hC0DE; step();
        chk("t6_restart_addr", 32'(bram_addra), 32'h0800);
        s_data = 16'hC0DF; step();
        s_valid = 1'b0; step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 5) == 0);
            len       = 16'($urandom_range(0, 6));
            base_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                    : 16'($urandom);
            abort     = ($urandom_range(0, 24) == 0);
            s_valid   = ($urandom_range(0, 2) != 0);
            s_data    = 16'($urandom);
            step();
        end
        idle_inputs();
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
